hc_sub_pipe: RTL
================

Name: hc_sub_pipe

Overview:
- Pipelined Han-Carlson parallel-prefix subtractor. It is the inverse-direction companion to the datapath prefix adders.
- Computes diff = a - b - bin and the borrow-out over WIDTH bits.
- Three-stage pipeline with valid/ready handshakes on both sides. Sits between an operand producer and a result consumer in the datapath collection.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat this cycle.
- in_a  in  WIDTH  minuend, unsigned.
- in_b  in  WIDTH  subtrahend, unsigned.
- in_bin  in  1  borrow-in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_diff  out  WIDTH  (in_a - in_b - in_bin) mod 2^WIDTH.
- out_bout  out  1  1 iff in_a < in_b + in_bin (unsigned).

Interface decision:
- One clock; reset is asynchronous and active-low: ports clk and rst_n.

Behaviour:
- Arithmetic: generate g_i = ~a_i & b_i; propagate p_i = ~(a_i ^ b_i). The borrow chain folds in in_bin as the position -1 generate. Exact modular result, no truncation surprises.
- S1 (input register): captures a, b, bin and computes g/p.
- S2 (prefix register): Han-Carlson tree over (g,p):
  - Odd-indexed Kogge-Stone levels: ceil(log2 WIDTH) levels.
  - Final even-index fix-up level.
  - Result is registered group borrows B_i.
- S3 (output register): diff_i = a_i ^ b_i ^ B_{i-1}; bout = B_{WIDTH-1}.
- Latency: exactly 3 cycles from input acceptance (in_valid & in_ready) to out_valid, when out_ready is held high.
- Throughput: one beat per cycle sustained.
- Per-stage valid bit v1..v3. A stage loads when it is empty or when its contents advance in the same cycle.
  - in_ready = ~v1 | advance1.
  - advance3 = out_valid & out_ready.
  - Bubbles collapse: a stalled S3 does not block S1/S2 from filling empty slots.
- in_ready depends only on state and out_ready; it never depends on in_valid. There is no combinational path from in_* data to out_*.
- Backpressure: while out_valid & ~out_ready, out_diff/out_bout/out_valid hold stable. Once all three stages are full, in_ready = 0.
- Simultaneous accept at the input and drain at the output with all stages full: both happen; the pipeline stays full.
- Reset (asynchronous assert, synchronous deassertion handled upstream):
  - v1..v3 = 0, so out_valid = 0 and in_ready = 1.
  - out_diff = 0, out_bout = 0, all data registers = 0.
- Reset mid-operation: all in-flight beats are discarded. There is no partial output.
- Data registers of empty stages may hold stale values, but out_diff/out_bout are only meaningful when out_valid = 1. The bench checks outputs only on handshake.

Optional Feature:
- Macro HC_SUB_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit) = signed two's-complement overflow of a - b - bin, computed as B_{WIDTH-1} ^ B_{WIDTH-2}.
  - Pipelined alongside diff and held under backpressure like the other outputs.
  - Reset value 0.
- Undefined: the port is absent. No extra flops.

Decomposition:
- Package hc_sub_pkg holds:
  - HC_SUB_STAGES = 3.
  - Typedef gp_t: struct {g, p} with width-parameterised vectors.
  - Function hc_levels(width) returning the prefix level count.
- Sub-module hc_borrow_net: a purely combinational Han-Carlson prefix network, (g, p, bin) -> group borrows B. Instantiated once, between the S1 and S2 registers.
- Handshake and stage registers live in hc_sub_pipe.

Test Plan:
- Reset, then a=4'hA, b=4'h3, bin=0 with out_ready=1 → on cycle 3: diff=4'h7, bout=0; in_ready stays 1 throughout.
- a=4'h3, b=4'hA, bin=1 → diff=4'h8, bout=1; with HC_SUB_OVF_EN: a=4'h7, b=4'hF (−1), bin=0 → diff=4'h8, ovf=1.
- Back-to-back: 16 beats on consecutive cycles (a=i, b=15−i, bin=i[0]) with out_ready=1 → 16 consecutive out_valid cycles in order, each matching the model.
- Backpressure: out_ready=0 for 6 cycles while driving 5 beats → exactly 3 accepted, in_ready=0 after the third, output held stable. Release → remaining beats drain in order with none lost or duplicated.
- Reset asserted with 2 beats in flight → out_valid falls asynchronously; after release, no stale beat appears; the next beat a=0, b=0, bin=1 → diff=4'hF, bout=1.
- Random: WIDTH=4, 8 and 37 with random valid/ready toggling for 10k beats → scoreboard against a - b - bin; check the no-combinational-in→out path with a formal or structural check.

Source files
------------

// File: rtl/hc_sub_pkg.sv
// Shared types and constants for the Han-Carlson prefix subtractor.
// Optional signed-overflow output is enabled with `define HC_SUB_OVF_EN.
package hc_sub_pkg;

  localparam int unsigned HC_SUB_STAGES    = 3;
  localparam int unsigned HC_SUB_MAX_WIDTH = 64;

  // Sized for the widest legal operand; narrower instances use the low bits.
  typedef struct packed {
    logic [HC_SUB_MAX_WIDTH-1:0] g;
    logic [HC_SUB_MAX_WIDTH-1:0] p;
  } gp_t;

  // Odd-index Kogge-Stone levels needed to span width bits: ceil(log2(width)).
  function automatic int unsigned hc_levels(input int unsigned width);
    int unsigned n;
    n = 0;
    while ((32'd1 << n) < width) begin
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/hc_sub_pipe_if.sv
// Operand/result handshake bundle for hc_sub_pipe.
// out_ovf exists only when HC_SUB_OVF_EN is defined.
interface hc_sub_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;
`ifdef HC_SUB_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_bin, out_ready,
    input  in_ready, out_valid, out_diff, out_bout
`ifdef HC_SUB_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_bin, out_ready,
    output in_ready, out_valid, out_diff, out_bout
`ifdef HC_SUB_OVF_EN
    , output out_ovf
`endif
  );

endinterface

// File: rtl/hc_borrow_net.sv
// Combinational Han-Carlson borrow network: (g, p, bin) -> group borrows B[i] over bits i..0.
module hc_borrow_net
  import hc_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  gp_t              gp_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] borrow_o
);

  localparam int unsigned Levels = hc_levels(WIDTH);

  logic [WIDTH-1:0] g_lvl [Levels+1];
  logic [WIDTH-1:0] p_lvl [Levels+1];

  // Upper bits of the max-width struct are structurally zero here.
  logic unused_gp;
  assign unused_gp = ^gp_i;

  always_comb begin
    int span;
    g_lvl[0] = gp_i.g[WIDTH-1:0];
    p_lvl[0] = gp_i.p[WIDTH-1:0];
    // Borrow-in acts as the position -1 generate, folded into bit 0.
    g_lvl[0][0] = gp_i.g[0] | (gp_i.p[0] & bin_i);
    p_lvl[0][0] = 1'b0;
    for (int l = 0; l < int'(Levels); l++) begin
      span = 1 << l;
      g_lvl[l+1] = g_lvl[l];
      p_lvl[l+1] = p_lvl[l];
      for (int i = 1; i < int'(WIDTH); i += 2) begin
        if (i >= span) begin
          g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-span]);
          p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-span];
        end
      end
    end
    borrow_o = g_lvl[Levels];
    // Even-index fix-up from the completed odd neighbour below.
    for (int i = 2; i < int'(WIDTH); i += 2) begin
      borrow_o[i] = g_lvl[Levels][i] | (p_lvl[Levels][i] & g_lvl[Levels][i-1]);
    end
  end

endmodule

// File: rtl/hc_sub_pipe.sv
// Three-stage pipelined Han-Carlson subtractor: diff = a - b - bin, with borrow-out.
// Define HC_SUB_OVF_EN to add the registered signed-overflow output out_ovf.
module hc_sub_pipe
  import hc_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  hc_sub_pipe_if.slave sub_io
);

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic adv1, adv2, adv3, load1, in_ready;

  gp_t              gp_d, gp_q;
  logic             bin1_q;
  logic [WIDTH-1:0] x2_d, x2_q;
  logic [WIDTH-1:0] borrow_d, borrow2_q;
  logic             bin2_q;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;

  // Each stage advances when the one below is empty or itself advancing.
  assign adv3     = v3_q & sub_io.out_ready;
  assign adv2     = v2_q & (~v3_q | adv3);
  assign adv1     = v1_q & (~v2_q | adv2);
  assign in_ready = ~v1_q | adv1;
  assign load1    = sub_io.in_valid & in_ready;

  assign v1_d = load1 | (v1_q & ~adv1);
  assign v2_d = adv1  | (v2_q & ~adv2);
  assign v3_d = adv2  | (v3_q & ~adv3);

  always_comb begin
    gp_d = '0;
    gp_d.g[WIDTH-1:0] = ~sub_io.in_a & sub_io.in_b;
    gp_d.p[WIDTH-1:0] = ~(sub_io.in_a ^ sub_io.in_b);
  end

  hc_borrow_net #(
    .WIDTH (WIDTH)
  ) u_borrow_net (
    .gp_i     (gp_q),
    .bin_i    (bin1_q),
    .borrow_o (borrow_d)
  );

  // a ^ b is recovered from the stored propagate.
  assign x2_d   = ~gp_q.p[WIDTH-1:0];
  assign diff_d = x2_q ^ {borrow2_q[WIDTH-2:0], bin2_q};
  assign bout_d = borrow2_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gp_q   <= '0;
      bin1_q <= 1'b0;
    end else if (load1) begin
      gp_q   <= gp_d;
      bin1_q <= sub_io.in_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_q      <= '0;
      borrow2_q <= '0;
      bin2_q    <= 1'b0;
    end else if (adv1) begin
      x2_q      <= x2_d;
      borrow2_q <= borrow_d;
      bin2_q    <= bin1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (adv2) begin
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

`ifdef HC_SUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv2) begin
      ovf_q <= borrow2_q[WIDTH-1] ^ borrow2_q[WIDTH-2];
    end
  end

  assign sub_io.out_ovf = ovf_q;
`endif

  assign sub_io.in_ready  = in_ready;
  assign sub_io.out_valid = v3_q;
  assign sub_io.out_diff  = diff_q;
  assign sub_io.out_bout  = bout_q;

endmodule
